// File: rtl/second_stage_eac_pkg.sv
// Shared types for the end-around-carry stage: FSM states, dual-rail pair codes
// and the default operand width.
package second_stage_eac_pkg;

  localparam int unsigned DEFAULT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    CORR = 2'd2,
    OUT  = 2'd3
  } state_t;

  // Pair code packed as {true_rail, complement_rail}.
  typedef enum logic [1:0] {
    RAIL_NULL    = 2'b00,
    RAIL_ZERO    = 2'b01,
    RAIL_ONE     = 2'b10,
    RAIL_ILLEGAL = 2'b11
  } rail_code_t;

endpackage

// File: rtl/second_stage_eac_dr_completion.sv
// Completion detector for one dual-rail bus: decoded value plus
// all-valid, all-null and any-illegal flags.
module dr_completion
  import second_stage_eac_pkg::*;
#(
  parameter int unsigned W = DEFAULT_W
) (
  input  logic [W-1:0] rail_t,
  input  logic [W-1:0] rail_f,
  output logic [W-1:0] value,
  output logic         complete,
  output logic         spacer,
  output logic         illegal
);

  logic [W-1:0] valid_bits;
  logic [W-1:0] null_bits;
  logic [W-1:0] illegal_bits;

  always_comb begin
    valid_bits   = '0;
    null_bits    = '0;
    illegal_bits = '0;
    for (int unsigned i = 0; i < W; i++) begin
      case (rail_code_t'({rail_t[i], rail_f[i]}))
        RAIL_ZERO, RAIL_ONE: valid_bits[i]   = 1'b1;
        RAIL_NULL:           null_bits[i]    = 1'b1;
        default:             illegal_bits[i] = 1'b1;
      endcase
    end
  end

  assign value    = rail_t;
  assign complete = &valid_bits;
  assign spacer   = &null_bits;
  assign illegal  = |illegal_bits;

endmodule

// File: rtl/second_stage_eac.sv
// Modulo-(2^W-1) adder stage: captures a dual-rail token under a four-phase
// protocol, adds with end-around carry and presents the result over valid/ready.
module second_stage_eac
  import second_stage_eac_pkg::*;
#(
  parameter int unsigned W         = DEFAULT_W,
  parameter bit          NORM_ZERO = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] a_0,
  input  logic [W-1:0] a_1,
  input  logic [W-1:0] b_0,
  input  logic [W-1:0] b_1,
  output logic         in_ack,
  output logic         err,
  output logic [W-1:0] r,
  output logic         out_valid,
  input  logic         out_ready
);

  state_t state, state_n;

  logic [W-1:0] a_val, b_val;
  logic         a_cmp, a_sp, a_ill;
  logic         b_cmp, b_sp, b_ill;
  logic         in_complete, in_spacer, in_illegal;

  logic         spacer_seen;
  logic [W-1:0] a_q, b_q, s_q;
  logic         c_q;

  logic         capture, do_add, do_corr, do_accept;
  logic [W-1:0] b_rot;
  logic [W:0]   add_sum, corr_sum;
  logic [W-1:0] t_norm;

  dr_completion #(.W(W)) u_dr_a (
    .rail_t   (a_0),
    .rail_f   (a_1),
    .value    (a_val),
    .complete (a_cmp),
    .spacer   (a_sp),
    .illegal  (a_ill)
  );

  dr_completion #(.W(W)) u_dr_b (
    .rail_t   (b_0),
    .rail_f   (b_1),
    .value    (b_val),
    .complete (b_cmp),
    .spacer   (b_sp),
    .illegal  (b_ill)
  );

  assign in_complete = a_cmp & b_cmp;
  assign in_spacer   = a_sp & b_sp;
  assign in_illegal  = a_ill | b_ill;

  // b(W) sits in the top bus bit but carries weight 2^W == 1 mod (2^W-1).
  assign b_rot    = {b_val[W-2:0], b_val[W-1]};
  assign add_sum  = {1'b0, a_q} + {1'b0, b_q};
  assign corr_sum = {1'b0, s_q} + {{W{1'b0}}, c_q};
  assign t_norm   = (NORM_ZERO && (corr_sum[W-1:0] == '1)) ? '0 : corr_sum[W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (capture)   state_n = ADD;
      ADD:                    state_n = CORR;
      CORR:                   state_n = OUT;
      OUT:     if (do_accept) state_n = IDLE;
      default:                state_n = IDLE;
    endcase
  end

  always_comb begin
    capture   = (state == IDLE) && !in_illegal && in_complete && spacer_seen;
    do_add    = (state == ADD);
    do_corr   = (state == CORR);
    do_accept = (state == OUT) && out_valid && out_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spacer_seen <= 1'b1;
      in_ack      <= 1'b0;
      err         <= 1'b0;
      out_valid   <= 1'b0;
      r           <= '0;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      c_q         <= 1'b0;
    end else begin
      err <= in_illegal;

      // Illegal codes take priority so a corrupted wave never counts as a spacer.
      if (in_illegal)     spacer_seen <= 1'b0;
      else if (in_spacer) spacer_seen <= 1'b1;
      else if (capture)   spacer_seen <= 1'b0;

      if (capture)        in_ack <= 1'b1;
      else if (in_spacer) in_ack <= 1'b0;

      if (capture) begin
        a_q <= a_val;
        b_q <= b_rot;
      end

      if (do_add) begin
        s_q <= add_sum[W-1:0];
        c_q <= add_sum[W];
      end

      if (do_corr) begin
        assert (corr_sum[W] == 1'b0);
        r         <= t_norm;
        out_valid <= 1'b1;
      end else if (do_accept) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
